kernel_window_builder: RTL and testbench
========================================

// Module: kernel_window_builder
// PURPOSE
//  Front end of the median pipeline. Accepts a raster pixel stream on an AXI4-Stream slave.
//  Buffers KERNEL_SIZE-1 image lines and emits a KERNEL_SIZE x KERNEL_SIZE window with valid and SOF.
//  Window, valid and SOF feed the median_processing kernel input directly.
// PARAMETERS
//  DATA_WIDTH   8    pixel width, bits
//  KERNEL_SIZE  5    window side; odd, >= 3
//  IMG_WIDTH    640  pixels per line; > KERNEL_SIZE
//  IMG_HEIGHT   512  lines per frame; > KERNEL_SIZE
// PORTS
//  i_clk               in   1            clock
//  i_aresetn           in   1            reset, synchronous, active-low
//  i_s_axis_tdata      in   DATA_WIDTH   pixel
//  i_s_axis_tvalid     in   1            pixel valid
//  o_s_axis_tready     out  1            ready; 1 whenever out of reset
//  i_s_axis_tuser      in   1            start of frame, marks pixel (0,0)
//  i_s_axis_tlast      in   1            end of line
//  o_image_kernel_buffer out [DATA_WIDTH-1:0] [0:K-1][0:K-1]  window
//  o_image_data_valid  out  1            window valid, 1-cycle pulse
//  o_start_of_frame    out  1            first window of frame
// BEHAVIOUR
//  - Reset: applied on an i_clk edge with i_aresetn=0. All outputs, window registers and counters go to 0.
//    State goes to IDLE. Line-buffer RAM contents are not reset.
//  - Accept: a beat is accepted when tvalid && tready. There is no backpressure; tready=1 from the first cycle after reset release.
//  - Counters: col 0..IMG_WIDTH-1 wraps to 0 and increments row; row 0..IMG_HEIGHT-1.
//    Widths are $clog2(IMG_WIDTH) and $clog2(IMG_HEIGHT).
//    Line position is taken from the column count; tlast is not used for positioning.
//  - FSM IDLE -> FILL: on an accepted beat with tuser=1. That beat is pixel (0,0).
//    In IDLE, beats with tuser=0 are accepted and dropped.
//  - FSM FILL -> RUN: when row reaches K-1.
//  - FSM RUN -> IDLE: after the beat at (IMG_WIDTH-1, IMG_HEIGHT-1) is accepted.
//  - tuser=1 in FILL/RUN: the frame restarts. That beat is (0,0), state goes to FILL, and no window is emitted for it.
//  - Line buffers: K-1 RAMs, depth IMG_WIDTH, read-before-write at address col.
//    On accept: lb[0][col]<=pixel; lb[k][col]<=lb[k-1][col] old value.
//  - Window orientation: row index 0 = oldest line (y-K+1), row K-1 = current line.
//    Column index 0 = oldest pixel (x-K+1), column K-1 = newest.
//  - Window update on accept: shift columns toward index 0.
//    Insert the new column {lb[K-2][col]..lb[0][col], pixel} at index K-1.
//  - Valid: o_image_data_valid=1 exactly one cycle after accepting (x,y) with x>=K-1 and y>=K-1.
//    The window is then centred on (x-(K-1)/2, y-(K-1)/2). Latency is 1 clk.
//    Windows per frame = (IMG_WIDTH-K+1)*(IMG_HEIGHT-K+1).
//    o_image_kernel_buffer holds its value between valids.
//  - o_start_of_frame: asserted with the first valid of each frame only, i.e. (K-1,K-1).
//  - tvalid gaps: no state change and no output pulse during gaps.
//  - Reset mid-frame: the frame is discarded. The next frame starts only on tuser.
// CONFIGURATION
//  - KWB_LINE_CHECK_EN defined adds output o_line_len_err (1 bit, reset 0).
//    It pulses 1 cycle after an accepted beat where tlast != (col==IMG_WIDTH-1).
//    Positioning is unchanged and the flag is informative only.
//  - KWB_LINE_CHECK_EN undefined: the port does not exist and tlast is ignored.
// STRUCTURE
//  - Shared package kernel_pkg:
//    DATA_WIDTH/KERNEL_SIZE default localparams;
//    typedef pixel_t;
//    typedef kernel_t (K x K of pixel_t);
//    enum kwb_state_t {IDLE, FILL, RUN}.
//  - Sub-module line_buffer_ram: single-port RAM, depth IMG_WIDTH, width DATA_WIDTH.
//    Read-before-write, combinational read of the addressed word. Instantiated K-1 times via generate.
// TESTING (DATA_WIDTH=8, K=5, IMG_WIDTH=8, IMG_HEIGHT=6; pixel value = y*8+x)
//  1 i_aresetn=0 for 3 clks mid-stream -> all outputs 0, tready=0.
//    Next clk after release -> tready=1.
//  2 Continuous frame, tuser on (0,0) -> 8 valids.
//    First valid: sof=1, kernel[0][0]=0, kernel[4][4]=36, kernel[2][2]=18.
//    Last valid: kernel[4][4]=47. sof=0 thereafter.
//  3 Same frame with tvalid low every other cycle -> identical 8 windows, each 1 clk after its accept.
//  4 30 beats with tuser=0 before the frame -> no valids; frame then behaves as scenario 2.
//  5 tuser reasserted at beat 20 (row 2) -> no valid from the aborted frame.
//    The restarted frame yields 8 valids, first with sof=1.
//  6 KWB_LINE_CHECK_EN defined, tlast at x=6 on row 1 -> o_line_len_err pulses once.
//    Window values are unchanged vs scenario 2.

Source files
------------

// File: rtl/kernel_window_builder_pkg.sv
// Shared definitions for the median pipeline front end: default pixel and
// kernel sizes, pixel/window types and the window builder state encoding.
package kernel_pkg;

  localparam int DATA_WIDTH  = 8;
  localparam int KERNEL_SIZE = 5;

  typedef logic [DATA_WIDTH-1:0] pixel_t;
  typedef pixel_t [0:KERNEL_SIZE-1][0:KERNEL_SIZE-1] kernel_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } kwb_state_t;

endpackage

// File: rtl/kernel_window_builder_if.sv
// AXI4-Stream pixel bus feeding the window builder (no backpressure path
// in practice, but tready is carried so the bus stays standard).
interface kernel_window_builder_if #(
  parameter int DATA_WIDTH = kernel_pkg::DATA_WIDTH
) ();

  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tuser;
  logic                  tlast;

  modport master (output tdata, output tvalid, output tuser, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tuser, input tlast, output tready);

endinterface

// File: rtl/kernel_window_builder_line_buffer_ram.sv
// line_buffer_ram: single-port line store, one word per pixel column.
// Combinational read of the addressed word, so a write in the same cycle
// still sees the old contents (read-before-write).
module line_buffer_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 640,
  localparam int ADDR_W    = $clog2(DEPTH)
) (
  input  logic                  i_clk,
  input  logic                  i_we,
  input  logic [ADDR_W-1:0]     i_addr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  assign o_rdata = mem[i_addr];

  // Store the incoming word; contents are deliberately never reset.
  always_ff @(posedge i_clk) begin
    if (i_we) mem[i_addr] <= i_wdata;
  end

endmodule

// File: rtl/kernel_window_builder.sv
// kernel_window_builder: takes a raster pixel stream, keeps KERNEL_SIZE-1
// previous lines and emits a KERNEL_SIZE x KERNEL_SIZE window with valid
// and start-of-frame one clock after the pixel that completes it.
// Build macro KWB_LINE_CHECK_EN adds o_line_len_err (tlast vs column count).
module kernel_window_builder #(
  parameter int DATA_WIDTH  = kernel_pkg::DATA_WIDTH,
  parameter int KERNEL_SIZE = kernel_pkg::KERNEL_SIZE,
  parameter int IMG_WIDTH   = 640,
  parameter int IMG_HEIGHT  = 512
) (
  input  logic                  i_clk,
  input  logic                  i_aresetn,
  kernel_window_builder_if.slave s_axis,
  output logic [0:KERNEL_SIZE-1][0:KERNEL_SIZE-1][DATA_WIDTH-1:0] o_image_kernel_buffer,
  output logic                  o_image_data_valid,
  output logic                  o_start_of_frame
`ifdef KWB_LINE_CHECK_EN
  ,
  output logic                  o_line_len_err
`endif
);

  import kernel_pkg::*;

  localparam int K     = KERNEL_SIZE;
  localparam int COL_W = $clog2(IMG_WIDTH);
  localparam int ROW_W = $clog2(IMG_HEIGHT);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_FILL = FILL;
  localparam logic [1:0] S_RUN  = RUN;

  typedef logic [0:K-1][0:K-1][DATA_WIDTH-1:0] win_t;

  logic [1:0]       state;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic             tready_q;
  win_t             win_q;
  win_t             win_next;

  logic [DATA_WIDTH-1:0] lb_rd [K-1];
  logic [DATA_WIDTH-1:0] lb_wr [K-1];

  // A tuser beat is always pixel (0,0), whatever state the frame was in.
  logic             accept;
  logic             sof_beat;
  logic             in_frame_beat;
  logic             process_beat;
  logic [COL_W-1:0] addr;
  logic             emit;
  logic             emit_sof;

  assign s_axis.tready = tready_q;
  assign accept        = s_axis.tvalid && tready_q;
  assign sof_beat      = accept && s_axis.tuser;
  assign in_frame_beat = accept && !s_axis.tuser && (state != S_IDLE);
  assign process_beat  = sof_beat || in_frame_beat;
  assign addr          = sof_beat ? '0 : col;
  assign emit          = in_frame_beat && (col >= COL_W'(K - 1)) && (row >= ROW_W'(K - 1));
  assign emit_sof      = emit && (col == COL_W'(K - 1)) && (row == ROW_W'(K - 1));

  // Line buffer chain: lb[0] takes the pixel, lb[k] takes lb[k-1]'s old word.
  for (genvar g = 0; g < K - 1; g++) begin : g_lb
    if (g == 0) begin : g_head
      assign lb_wr[g] = s_axis.tdata;
    end else begin : g_tail
      assign lb_wr[g] = lb_rd[g-1];
    end
    line_buffer_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (IMG_WIDTH)
    ) u_ram (
      .i_clk   (i_clk),
      .i_we    (process_beat),
      .i_addr  (addr),
      .i_wdata (lb_wr[g]),
      .o_rdata (lb_rd[g])
    );
  end

  // Next window: shift columns toward index 0, new column enters at K-1
  // with the oldest line (deepest line buffer) in row 0.
  always_comb begin
    win_next = win_q;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K - 1; c++) begin
        win_next[r][c] = win_q[r][c+1];
      end
    end
    for (int r = 0; r < K - 1; r++) begin
      win_next[r][K-1] = lb_rd[K-2-r];
    end
    win_next[K-1][K-1] = s_axis.tdata;
  end

  // Frame position counters and IDLE/FILL/RUN sequencing.
  always_ff @(posedge i_clk) begin
    if (!i_aresetn) begin
      state <= S_IDLE;
      col   <= '0;
      row   <= '0;
    end else if (sof_beat) begin
      state <= S_FILL;
      col   <= COL_W'(1);
      row   <= '0;
    end else if (in_frame_beat) begin
      if (col == COL_LAST) begin
        col <= '0;
        if (row == ROW_LAST) begin
          row   <= '0;
          state <= S_IDLE;
        end else begin
          row <= row + 1'b1;
          if (state == S_FILL && row == ROW_W'(K - 2)) state <= S_RUN;
        end
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // Working window register, advanced on every positioned beat.
  always_ff @(posedge i_clk) begin
    if (!i_aresetn) win_q <= '0;
    else if (process_beat) win_q <= win_next;
  end

  // Output stage: ready after reset, window captured only when it is valid.
  always_ff @(posedge i_clk) begin
    if (!i_aresetn) begin
      tready_q              <= 1'b0;
      o_image_data_valid    <= 1'b0;
      o_start_of_frame      <= 1'b0;
      o_image_kernel_buffer <= '0;
    end else begin
      tready_q           <= 1'b1;
      o_image_data_valid <= emit;
      o_start_of_frame   <= emit_sof;
      if (emit) o_image_kernel_buffer <= win_next;
    end
  end

`ifdef KWB_LINE_CHECK_EN
  // Flag beats whose tlast disagrees with the column count; positioning ignores it.
  always_ff @(posedge i_clk) begin
    if (!i_aresetn) o_line_len_err <= 1'b0;
    else o_line_len_err <= process_beat && (s_axis.tlast != (addr == COL_LAST));
  end
`else
  logic unused_tlast;
  assign unused_tlast = s_axis.tlast;
`endif

endmodule

// File: tb/tb_kernel_window_builder.sv
// Directed bench for kernel_window_builder (K=5, 8x6 image, pixel = y*8+x).
module tb_kernel_window_builder;

  localparam int DW = 8;
  localparam int K  = 5;
  localparam int W  = 8;
  localparam int H  = 6;

  typedef logic [0:K-1][0:K-1][DW-1:0] win_t;

  logic clk = 1'b0;
  logic aresetn;
  win_t kbuf;
  logic vld;
  logic sof;
`ifdef KWB_LINE_CHECK_EN
  logic lerr;
`endif

  int checks = 0;
  int errors = 0;

  kernel_window_builder_if #(.DATA_WIDTH(DW)) s_axis ();

  kernel_window_builder #(
    .DATA_WIDTH  (DW),
    .KERNEL_SIZE (K),
    .IMG_WIDTH   (W),
    .IMG_HEIGHT  (H)
  ) dut (
    .i_clk                 (clk),
    .i_aresetn             (aresetn),
    .s_axis                (s_axis),
    .o_image_kernel_buffer (kbuf),
    .o_image_data_valid    (vld),
    .o_start_of_frame      (sof)
`ifdef KWB_LINE_CHECK_EN
    ,
    .o_line_len_err        (lerr)
`endif
  );

  always #5 clk = ~clk;

  // Window centred so that its newest pixel is (x,y): entry [r][c] is pixel (x-K+1+c, y-K+1+r).
  function automatic win_t exp_win(input int x, input int y);
    win_t w;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K; c++) begin
        w[r][c] = DW'((y - K + 1 + r) * W + (x - K + 1 + c));
      end
    end
    return w;
  endfunction

  task automatic beat(input logic v, input logic [DW-1:0] d, input logic u, input logic l);
    s_axis.tvalid = v;
    s_axis.tdata  = d;
    s_axis.tuser  = u;
    s_axis.tlast  = l;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int seen;
    aresetn = 1'b0;
    beat(1'b0, '0, 1'b0, 1'b0);
    beat(1'b0, '0, 1'b0, 1'b0);
    checks++; if (vld !== 1'b0) begin errors++; $display("FAIL por_valid: got %b want 0", vld); end
    checks++; if (s_axis.tready !== 1'b0) begin errors++; $display("FAIL por_tready: got %b want 0", s_axis.tready); end
    aresetn = 1'b1;
    beat(1'b0, '0, 1'b0, 1'b0);
    checks++; if (s_axis.tready !== 1'b1) begin errors++; $display("FAIL release_tready: got %b want 1", s_axis.tready); end
    // 38 beats reach (5,4), which produces a window just before the reset hits.
    for (int i = 0; i < 38; i++) beat(1'b1, DW'(i), i == 0, (i % W) == W - 1);
    checks++; if (vld !== 1'b1) begin errors++; $display("FAIL prereset_valid: got %b want 1", vld); end
    aresetn = 1'b0;
    for (int i = 38; i < 41; i++) beat(1'b1, DW'(i), 1'b0, 1'b0);
    checks++; if (vld !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", vld); end
    checks++; if (sof !== 1'b0) begin errors++; $display("FAIL rst_sof: got %b want 0", sof); end
    checks++; if (kbuf !== '0) begin errors++; $display("FAIL rst_kernel: got %h want 0", kbuf); end
    checks++; if (s_axis.tready !== 1'b0) begin errors++; $display("FAIL rst_tready: got %b want 0", s_axis.tready); end
`ifdef KWB_LINE_CHECK_EN
    checks++; if (lerr !== 1'b0) begin errors++; $display("FAIL rst_line_err: got %b want 0", lerr); end
`endif
    aresetn = 1'b1;
    beat(1'b1, 8'h11, 1'b0, 1'b0);
    checks++; if (s_axis.tready !== 1'b1) begin errors++; $display("FAIL rst_release_tready: got %b want 1", s_axis.tready); end
    // Without tuser the discarded frame must not resume.
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      beat(1'b1, DW'(41 + i), 1'b0, 1'b0);
      if (vld !== 1'b0) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL rst_no_resume: got %0d valids want 0", seen); end
  endtask

  task automatic test_frame(input string tag, input bit gaps, input bit bad_tlast);
    int   nv;
    win_t first_w;
    win_t last_w;
    logic l;
`ifdef KWB_LINE_CHECK_EN
    int   nerr;
    logic el;
    nerr = 0;
`endif
    nv      = 0;
    first_w = '0;
    last_w  = '0;
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        bit ev;
        bit es;
        if (gaps) begin
          beat(1'b0, 8'hEE, 1'b1, 1'b1);
          checks++; if (vld !== 1'b0) begin errors++; $display("FAIL %s gap_valid before (%0d,%0d): got %b want 0", tag, x, y, vld); end
        end
        l = (x == W - 1) || (bad_tlast && y == 1 && x == 6);
        beat(1'b1, DW'(y * W + x), (x == 0 && y == 0), l);
        ev = (x >= K - 1) && (y >= K - 1);
        es = (x == K - 1) && (y == K - 1);
        checks++; if (vld !== ev) begin errors++; $display("FAIL %s valid at (%0d,%0d): got %b want %b", tag, x, y, vld, ev); end
        checks++; if (sof !== es) begin errors++; $display("FAIL %s sof at (%0d,%0d): got %b want %b", tag, x, y, sof, es); end
        if (ev) begin
          nv++;
          if (es) first_w = kbuf;
          last_w = kbuf;
          checks++; if (kbuf !== exp_win(x, y)) begin errors++; $display("FAIL %s window at (%0d,%0d): got %h want %h", tag, x, y, kbuf, exp_win(x, y)); end
        end
`ifdef KWB_LINE_CHECK_EN
        el = l != (x == W - 1);
        if (lerr === 1'b1) nerr++;
        checks++; if (lerr !== el) begin errors++; $display("FAIL %s line_err at (%0d,%0d): got %b want %b", tag, x, y, lerr, el); end
`endif
      end
    end
    checks++; if (nv !== 8) begin errors++; $display("FAIL %s valid_count: got %0d want 8", tag, nv); end
    checks++; if (first_w[0][0] !== 8'd0) begin errors++; $display("FAIL %s first_k00: got %0d want 0", tag, first_w[0][0]); end
    checks++; if (first_w[4][4] !== 8'd36) begin errors++; $display("FAIL %s first_k44: got %0d want 36", tag, first_w[4][4]); end
    checks++; if (first_w[2][2] !== 8'd18) begin errors++; $display("FAIL %s first_k22: got %0d want 18", tag, first_w[2][2]); end
    checks++; if (last_w[4][4] !== 8'd47) begin errors++; $display("FAIL %s last_k44: got %0d want 47", tag, last_w[4][4]); end
    beat(1'b0, 8'h00, 1'b0, 1'b0);
    checks++; if (vld !== 1'b0) begin errors++; $display("FAIL %s idle_valid: got %b want 0", tag, vld); end
    checks++; if (kbuf !== exp_win(W - 1, H - 1)) begin errors++; $display("FAIL %s hold: got %h want %h", tag, kbuf, exp_win(W - 1, H - 1)); end
`ifdef KWB_LINE_CHECK_EN
    checks++; if (nerr !== (bad_tlast ? 1 : 0)) begin errors++; $display("FAIL %s line_err_pulses: got %0d want %0d", tag, nerr, bad_tlast ? 1 : 0); end
`endif
  endtask

  task automatic test_leading_junk();
    int seen;
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      beat(1'b1, DW'(8'h5A + i), 1'b0, (i % 3) == 0);
      if (vld !== 1'b0) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL junk_valids: got %0d want 0", seen); end
    test_frame("junk_frame", 1'b0, 1'b0);
  endtask

  task automatic test_restart();
    int seen;
    seen = 0;
    // Aborted frame uses distinct pixel values so any leak into the restarted frame shows up.
    for (int i = 0; i < 20; i++) begin
      beat(1'b1, DW'(200 - i), i == 0, (i % W) == W - 1);
      if (vld !== 1'b0) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL restart_aborted_valids: got %0d want 0", seen); end
    test_frame("restart", 1'b0, 1'b0);
  endtask

  initial begin
    aresetn       = 1'b0;
    s_axis.tvalid = 1'b0;
    s_axis.tdata  = '0;
    s_axis.tuser  = 1'b0;
    s_axis.tlast  = 1'b0;
    test_reset();
    test_frame("continuous", 1'b0, 1'b0);
    test_frame("gaps", 1'b1, 1'b0);
    test_leading_junk();
    test_restart();
`ifdef KWB_LINE_CHECK_EN
    test_frame("line_check", 1'b0, 1'b1);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
